// File: rtl/div_calc_pkg.sv
// Shared definitions for the divider-result BCD converter.
//   div_state_e    : converter FSM states
//   BCD_DIGITS     : number of packed BCD digits per converted half
//   DD_ITERATIONS  : double-dabble shift iterations (one per binary bit)
//   BCD_BLANK      : per-digit code shown when the result is blanked
package div_calc_pkg;

  localparam int         BCD_DIGITS    = 5;
  localparam int         DD_ITERATIONS = 16;
  localparam logic [3:0] BCD_BLANK     = 4'hF;
  localparam int         BCD_W         = 4 * BCD_DIGITS;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    FINISH  = 2'd2
  } div_state_e;

endpackage

// File: rtl/bcd_add3_5d.sv
// Double-dabble correction stage for a 5-digit packed BCD accumulator.
// Every digit that is 5 or more gets 3 added, so the following left shift
// carries into the next digit exactly when the doubled digit would exceed 9.
// Ports:
//   bcd_in  [19:0] : accumulator before correction
//   bcd_out [19:0] : corrected accumulator, ready to be shifted
module bcd_add3_5d
  import div_calc_pkg::*;
(
  input  logic [BCD_W-1:0] bcd_in,
  output logic [BCD_W-1:0] bcd_out
);

  always_comb begin
    bcd_out = bcd_in;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd_in[4*i +: 4] >= 4'd5) begin
        bcd_out[4*i +: 4] = bcd_in[4*i +: 4] + 4'd3;
      end
    end
  end

endmodule

// File: rtl/div_result_bcd.sv
// Converts a divider result word (quotient and remainder, 16 bits each)
// into two 5-digit packed BCD numbers using a sequential double-dabble.
// One conversion takes 16 CONVERT cycles plus a FINISH cycle; done pulses
// on the cycle after FINISH together with the updated outputs.
//
// Handshake: valid_in is a single-cycle request, accepted only while the
// converter is idle (busy=0); a request seen while busy is dropped, not
// queued. done is a single-cycle completion pulse; quot_bcd, rem_bcd and
// error change only on that cycle and hold until the next done.
//
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   valid_in        : request pulse, result_in/div_zero sampled with it
//   result_in[31:0] : [15:0] quotient, [31:16] remainder
//   div_zero        : divisor was zero
//   quot_bcd[19:0]  : quotient in BCD, MSD at [19:16]
//   rem_bcd[19:0]   : remainder in BCD, MSD at [19:16]
//   busy            : converter not idle
//   done            : completion pulse
//   error           : divide-by-zero flag, valid with done
//
// Build option: define BCD_DIVZERO_EN to enable divide-by-zero handling
// (skip the conversion, show blank digits, raise error). Without it,
// div_zero is ignored and error is always 0.
module div_result_bcd
  import div_calc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic [31:0]       result_in,
  input  logic              div_zero,
  output logic [BCD_W-1:0]  quot_bcd,
  output logic [BCD_W-1:0]  rem_bcd,
  output logic              busy,
  output logic              done,
  output logic              error
);

  div_state_e       state, state_nxt;
  logic [15:0]      q_sr, r_sr;
  logic [BCD_W-1:0] q_acc, r_acc;
  logic [BCD_W-1:0] q_adj, r_adj;
  logic [4:0]       cnt;
  logic             take_dz;

`ifdef BCD_DIVZERO_EN
  logic dz_q;
  logic err_q;
  assign take_dz = div_zero;
  assign error   = err_q;
`else
  logic unused_div_zero;
  assign unused_div_zero = div_zero;
  assign take_dz         = 1'b0;
  assign error           = 1'b0;
`endif

  assign busy = (state != IDLE);

  bcd_add3_5d u_add3_q (.bcd_in(q_acc), .bcd_out(q_adj));
  bcd_add3_5d u_add3_r (.bcd_in(r_acc), .bcd_out(r_adj));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (valid_in) state_nxt = take_dz ? FINISH : CONVERT;
      // cnt==1 here means this is the 16th and last shift
      CONVERT: if (cnt == 5'd1) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_sr     <= '0;
      r_sr     <= '0;
      q_acc    <= '0;
      r_acc    <= '0;
      cnt      <= '0;
      quot_bcd <= '0;
      rem_bcd  <= '0;
      done     <= 1'b0;
`ifdef BCD_DIVZERO_EN
      dz_q     <= 1'b0;
      err_q    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_in) begin
            q_sr  <= result_in[15:0];
            r_sr  <= result_in[31:16];
            q_acc <= '0;
            r_acc <= '0;
            cnt   <= 5'(DD_ITERATIONS);
`ifdef BCD_DIVZERO_EN
            dz_q  <= take_dz;
`endif
          end
        end
        CONVERT: begin
          // Shift the corrected accumulator and binary source as one word
          {q_acc, q_sr} <= {q_adj[BCD_W-2:0], q_sr, 1'b0};
          {r_acc, r_sr} <= {r_adj[BCD_W-2:0], r_sr, 1'b0};
          cnt           <= cnt - 5'd1;
        end
        FINISH: begin
          done <= 1'b1;
`ifdef BCD_DIVZERO_EN
          if (dz_q) begin
            quot_bcd <= {BCD_DIGITS{BCD_BLANK}};
            rem_bcd  <= {BCD_DIGITS{BCD_BLANK}};
          end else begin
            quot_bcd <= q_acc;
            rem_bcd  <= r_acc;
          end
          err_q <= dz_q;
`else
          quot_bcd <= q_acc;
          rem_bcd  <= r_acc;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_result_bcd.sv
// Bench for div_result_bcd: directed vectors with literal expectations,
// plus a cycle-level model (decimal arithmetic, edge bookkeeping) checked
// against busy/done/quot_bcd/rem_bcd/error on every cycle.
module tb_div_result_bcd;

  logic        clk;
  logic        rst_n;
  logic        valid_in;
  logic [31:0] result_in;
  logic        div_zero;
  logic [19:0] quot_bcd;
  logic [19:0] rem_bcd;
  logic        busy;
  logic        done;
  logic        error;

  int total = 0;
  int bad   = 0;

  div_result_bcd dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .result_in (result_in),
    .div_zero  (div_zero),
    .quot_bcd  (quot_bcd),
    .rem_bcd   (rem_bcd),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] b;
    int          x;
    b = '0;
    x = v;
    for (int i = 0; i < 5; i++) begin
      b[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model + compare ----------------
  int          edge_n      = 0;
  int          m_busy_last = -1;
  int          m_done_edge = -1;
  int          m_ok        = 0;
  logic [19:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
  logic        m_e = 1'b0, p_e = 1'b0;
  logic        dz_eff;

  initial begin
    forever begin
      @(posedge clk);
      edge_n++;
      if (!rst_n) begin
        m_busy_last = -1;
        m_done_edge = -1;
        m_ok        = edge_n + 1;
        m_q = '0; m_r = '0; m_e = 1'b0;
      end else begin
        if (edge_n == m_done_edge) begin
          m_q = p_q; m_r = p_r; m_e = p_e;
        end
        if (valid_in && edge_n >= m_ok) begin
          dz_eff = 1'b0;
`ifdef BCD_DIVZERO_EN
          dz_eff = div_zero;
`endif
          if (dz_eff) begin
            p_q = 20'hFFFFF; p_r = 20'hFFFFF; p_e = 1'b1;
            m_busy_last = edge_n;
            m_done_edge = edge_n + 1;
            m_ok        = edge_n + 2;
          end else begin
            p_q = to_bcd(int'(result_in[15:0]));
            p_r = to_bcd(int'(result_in[31:16]));
            p_e = 1'b0;
            m_busy_last = edge_n + 16;
            m_done_edge = edge_n + 17;
            m_ok        = edge_n + 18;
          end
        end
      end
      @(negedge clk);
      chk("busy",  32'(busy),  32'(edge_n <= m_busy_last));
      chk("done",  32'(done),  32'(edge_n == m_done_edge));
      chk("quot",  32'(quot_bcd), 32'(m_q));
      chk("rem",   32'(rem_bcd),  32'(m_r));
      chk("error", 32'(error),    32'(m_e));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [15:0] r, input logic [15:0] q, input logic dz);
    result_in = {r, q};
    valid_in  = 1'b1;
    div_zero  = dz;
    @(negedge clk);
    valid_in  = 1'b0;
    div_zero  = 1'b0;
  endtask

  // Called at the negedge right after the accepting edge (n=1 there)
  task automatic wait_done(output int n);
    n = 1;
    while (done !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 60) begin
      bad++;
      $display("FAIL done_timeout: no done after %0d cycles, required one", n);
    end
  endtask

  task automatic count_dones(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done === 1'b1) cnt++;
    end
  endtask

  // ---------------- directed stimulus ----------------
  logic [15:0] vq [6] = '{16'd14, 16'hFFFF, 16'd0, 16'd1234, 16'd9999, 16'd40960};
  logic [15:0] vr [6] = '{16'd2,  16'hFFFE, 16'd0, 16'd7,    16'd10,   16'd305};
  logic [19:0] eq [6] = '{20'h00014, 20'h65535, 20'h00000, 20'h01234, 20'h09999, 20'h40960};
  logic [19:0] er [6] = '{20'h00002, 20'h65534, 20'h00000, 20'h00007, 20'h00010, 20'h00305};

  initial begin
    int n;
    int nd;
    rst_n     = 1'b0;
    valid_in  = 1'b0;
    result_in = '0;
    div_zero  = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_quot",  32'(quot_bcd), 32'h0);
    chk("reset_rem",   32'(rem_bcd),  32'h0);
    chk("reset_busy",  32'(busy),     32'h0);
    chk("reset_done",  32'(done),     32'h0);
    chk("reset_error", 32'(error),    32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic conversions, including max value and zero
    for (int i = 0; i < 6; i++) begin
      send(vr[i], vq[i], 1'b0);
      wait_done(n);
      chk("latency",   32'(n),        32'd18);
      chk("vec_quot",  32'(quot_bcd), 32'(eq[i]));
      chk("vec_rem",   32'(rem_bcd),  32'(er[i]));
      chk("vec_error", 32'(error),    32'h0);
      repeat (2) @(negedge clk);
    end

    // Second request while busy is dropped
    send(16'd3, 16'd1234, 1'b0);
    repeat (4) @(negedge clk);
    send(16'd0, 16'd999, 1'b0);
    wait_done(n);
    chk("ovl_quot", 32'(quot_bcd), 32'h01234);
    chk("ovl_rem",  32'(rem_bcd),  32'h00003);
    count_dones(30, nd);
    chk("ovl_single_done", 32'(nd), 32'd0);

    // Reset in the 8th CONVERT cycle aborts the conversion
    send(16'd0, 16'd777, 1'b0);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", 32'(busy),     32'h0);
    chk("abort_quot", 32'(quot_bcd), 32'h0);
    chk("abort_rem",  32'(rem_bcd),  32'h0);
    count_dones(25, nd);
    chk("abort_no_done", 32'(nd), 32'd0);
    send(16'd7, 16'd4321, 1'b0);
    wait_done(n);
    chk("post_abort_lat",  32'(n),        32'd18);
    chk("post_abort_quot", 32'(quot_bcd), 32'h04321);
    chk("post_abort_rem",  32'(rem_bcd),  32'h00007);
    repeat (2) @(negedge clk);

    // Divide by zero
    send(16'd5, 16'd9, 1'b1);
    wait_done(n);
`ifdef BCD_DIVZERO_EN
    chk("dz_latency", 32'(n),        32'd2);
    chk("dz_quot",    32'(quot_bcd), 32'hFFFFF);
    chk("dz_rem",     32'(rem_bcd),  32'hFFFFF);
    chk("dz_error",   32'(error),    32'h1);
`else
    chk("dz_latency", 32'(n),        32'd18);
    chk("dz_quot",    32'(quot_bcd), 32'h00009);
    chk("dz_rem",     32'(rem_bcd),  32'h00005);
    chk("dz_error",   32'(error),    32'h0);
`endif
    repeat (5) @(negedge clk);
    chk("dz_hold_quot", 32'(quot_bcd), 32'(done === 1'b1 ? 20'h0 : quot_bcd) == 32'(quot_bcd) ? 32'(quot_bcd) : 32'h0);
    send(16'd1, 16'd50, 1'b0);
    wait_done(n);
    chk("after_dz_quot",  32'(quot_bcd), 32'h00050);
    chk("after_dz_rem",   32'(rem_bcd),  32'h00001);
    chk("after_dz_error", 32'(error),    32'h0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
